// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word, RAM handshake state and the memory arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DSERVE = 2'b01,
        ISERVE = 2'b10,
        FAULT  = 2'b11
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// starvation guard for fetches, per-grant timeout and a sticky fault state.
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests (one bubble between grants)
// DSERVE | data port owns the RAM until ACCESS, drop, ERROR or timeout
// ISERVE | fetch port owns the RAM until ACCESS, drop, ERROR or timeout
// FAULT  | RAM error or timeout seen; RAM idle, both ports stalled until reset
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int STARVE  = 2
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      fault
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam int SW = ($clog2(STARVE + 1) > 1) ? $clog2(STARVE + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    arb_state_t    state, state_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic [SW-1:0] starve_cnt, starve_cnt_n;

    logic d_req;
    logic serving;
    logic serve_req;
    logic complete;

    assign d_req     = dREN | dWEN;
    assign serving   = (state == DSERVE) || (state == ISERVE);
    assign serve_req = (state == DSERVE) ? d_req : iREN;
    assign complete  = serving && serve_req && (ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_n;
            tmo_cnt    <= tmo_cnt_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        tmo_cnt_n    = tmo_cnt;
        starve_cnt_n = starve_cnt;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iload        = '0;
        dload        = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        fault        = 1'b0;

        unique case (state)
            IDLE: begin
                tmo_cnt_n = '0;
                if (!iREN) starve_cnt_n = '0;
                // A fetch that has watched STARVE data grants go by takes priority.
                if (iREN && (starve_cnt >= STARVE_MAX)) begin
                    state_n      = ISERVE;
                    starve_cnt_n = '0;
                end else if (d_req) begin
                    state_n = DSERVE;
                    if (iREN) starve_cnt_n = starve_cnt + SW'(1);
                end else if (iREN) begin
                    state_n      = ISERVE;
                    starve_cnt_n = '0;
                end
            end
            DSERVE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~complete;
                dload    = complete ? ramload : '0;
            end
            ISERVE: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~complete;
                iload   = complete ? ramload : '0;
            end
            FAULT: begin
                fault = 1'b1;
            end
        endcase

        // Shared exit logic of both serve states; a dropped request ends the grant silently.
        if (serving) begin
            if (!serve_req || complete) begin
                state_n = IDLE;
            end else if ((ramstate == ERROR) || (tmo_cnt >= TMO_LAST)) begin
                state_n = FAULT;
            end else begin
                tmo_cnt_n = tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle comparison against a transaction-level
// model of grant ownership, plus literal expectations for the key scenarios.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int STARVE  = 2;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    word_t     iload, dload, ramaddr, ramstore;
    logic      iwait, dwait, ramREN, ramWEN, fault;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .fault(fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s' at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM (0 nobody, 1 data, 2 fetch), how long the
    // current owner has waited, and how many data grants a fetch has watched.
    int m_owner = 0, m_waited = 0, m_streak = 0;
    bit m_fault = 1'b0;
    bit m_still;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner = 0; m_waited = 0; m_streak = 0; m_fault = 1'b0;
        end else if (!m_fault) begin
            if (m_owner == 0) begin
                m_waited = 0;
                if (!iREN) m_streak = 0;
                if (iREN && m_streak >= STARVE) begin
                    m_owner = 2; m_streak = 0;
                end else if (dREN || dWEN) begin
                    m_owner = 1;
                    if (iREN) m_streak++;
                end else if (iREN) begin
                    m_owner = 2; m_streak = 0;
                end
            end else begin
                m_still = (m_owner == 1) ? (dREN || dWEN) : iREN;
                if (!m_still || ramstate == ACCESS) m_owner = 0;
                else if (ramstate == ERROR) m_fault = 1'b1;
                else begin
                    m_waited++;
                    if (m_waited >= TIMEOUT) m_fault = 1'b1;
                end
            end
        end
    end

    logic  e_ren, e_wen, e_iwait, e_dwait;
    word_t e_addr, e_store, e_iload, e_dload;
    int    i_done_cnt = 0, d_done_cnt = 0;
    word_t last_iload = '0;
    string glog = "";

    always @(negedge CLK) begin
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        e_iload = '0; e_dload = '0; e_iwait = 1'b1; e_dwait = 1'b1;
        if (!m_fault && m_owner == 1) begin
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
            if ((dREN || dWEN) && ramstate == ACCESS) begin
                e_dwait = 1'b0; e_dload = ramload;
            end
        end else if (!m_fault && m_owner == 2) begin
            e_addr = iaddr; e_ren = iREN;
            if (iREN && ramstate == ACCESS) begin
                e_iwait = 1'b0; e_iload = ramload;
            end
        end
        chk("cyc_ramREN", 32'(ramREN), 32'(e_ren));
        chk("cyc_ramWEN", 32'(ramWEN), 32'(e_wen));
        chk("cyc_ramaddr", ramaddr, e_addr);
        chk("cyc_ramstore", ramstore, e_store);
        chk("cyc_iwait", 32'(iwait), 32'(e_iwait));
        chk("cyc_dwait", 32'(dwait), 32'(e_dwait));
        chk("cyc_iload", iload, e_iload);
        chk("cyc_dload", dload, e_dload);
        chk("cyc_fault", 32'(fault), 32'(m_fault));
        if (iwait === 1'b0) begin i_done_cnt++; last_iload = iload; glog = {glog, "I"}; end
        if (dwait === 1'b0) begin d_done_cnt++; glog = {glog, "D"}; end
    end

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        ramstate = FREE;
    endtask

    // Leaves the bench at posedge+1 with reset released and counters cleared.
    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        i_done_cnt = 0; d_done_cnt = 0; glog = ""; last_iload = '0;
    endtask

    int fcyc;

    initial begin
        nRST = 1'b0;
        idle_inputs();
        #2;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);

        // Fetch with two BUSY cycles before ACCESS.
        do_reset();
        iaddr = 32'h40; iREN = 1'b1; ramstate = BUSY; ramload = 32'h3C010001;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1 ramstate = ACCESS;
        @(negedge CLK);
        chk("fetch_done_iwait", 32'(iwait), 32'd0);
        chk("fetch_ramaddr", ramaddr, 32'h40);
        @(posedge CLK); #1 ramstate = BUSY;
        @(negedge CLK);
        chk("fetch_bubble_ramREN", 32'(ramREN), 32'd0);
        @(posedge CLK); #1 iREN = 1'b0;
        repeat (3) @(posedge CLK); #1;
        chk("fetch_iwait_low_cycles", i_done_cnt, 32'd1);
        chk("fetch_iload", last_iload, 32'h3C010001);

        // Simultaneous fetch and write: data first, fetch after one bubble.
        do_reset();
        iaddr = 32'h200; iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD;
        ramstate = ACCESS;
        @(negedge CLK);
        chk("both_idle_ramWEN", 32'(ramWEN), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("both_d_ramWEN", 32'(ramWEN), 32'd1);
        chk("both_d_ramREN", 32'(ramREN), 32'd0);
        chk("both_d_ramaddr", ramaddr, 32'h100);
        chk("both_d_ramstore", ramstore, 32'hDEAD);
        @(posedge CLK); #1 dWEN = 1'b0;
        @(negedge CLK);
        chk("both_bubble_ramREN", 32'(ramREN), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("both_i_ramREN", 32'(ramREN), 32'd1);
        chk("both_i_ramaddr", ramaddr, 32'h200);
        @(posedge CLK); #1 iREN = 1'b0;
        chk_str("both_order", glog, "DI");

        // Starvation guard: data held, fetch held, RAM always ready.
        do_reset();
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h400;
        ramload = 32'h11; ramstate = ACCESS;
        repeat (12) @(posedge CLK); #1;
        chk_str("starve_order", glog, "DDIDDI");

        // Timeout: BUSY forever on a data read.
        do_reset();
        dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
        fcyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (fault === 1'b1) begin fcyc = c; break; end
        end
        chk("timeout_fault_cycle", fcyc, 32'd17);
        chk("timeout_ramREN", 32'(ramREN), 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("timeout_sticky", 32'(fault), 32'd1);
        chk("timeout_dwait", 32'(dwait), 32'd1);
        chk("timeout_no_done", d_done_cnt, 32'd0);
        @(posedge CLK); #1 nRST = 1'b0;
        #2 chk("timeout_reset_clears", 32'(fault), 32'd0);
        #1 nRST = 1'b1;

        // Data read withdrawn after one BUSY cycle.
        do_reset();
        dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("drop_serve_ramREN", 32'(ramREN), 32'd1);
        @(posedge CLK); #1 dREN = 1'b0;
        @(negedge CLK);
        chk("drop_ramREN", 32'(ramREN), 32'd0);
        chk("drop_dwait", 32'(dwait), 32'd1);
        @(posedge CLK); #1 dREN = 1'b1; ramstate = ACCESS;
        @(negedge CLK);
        chk("drop_back_idle_dwait", 32'(dwait), 32'd1);
        @(posedge CLK); #1;
        chk("drop_no_done", d_done_cnt, 32'd0);
        @(negedge CLK);
        chk("drop_regrant_dwait", 32'(dwait), 32'd0);
        @(posedge CLK); #1 dREN = 1'b0;

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        iREN = 1'b1; iaddr = 32'h700; ramstate = BUSY;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("arst_pre_ramREN", 32'(ramREN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_ramREN", 32'(ramREN), 32'd0);
        chk("arst_iwait", 32'(iwait), 32'd1);
        chk("arst_ramaddr", ramaddr, 32'd0);
        nRST = 1'b1;
        #1 chk("arst_released_idle", 32'(ramREN), 32'd0);
        @(negedge CLK);
        chk("arst_regrant_ramREN", 32'(ramREN), 32'd1);
        chk("arst_no_done", i_done_cnt, 32'd0);

        // RAM error during a fetch.
        do_reset();
        iREN = 1'b1; iaddr = 32'h800; ramstate = ERROR;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("error_fault", 32'(fault), 32'd1);
        chk("error_iwait", 32'(iwait), 32'd1);
        chk("error_ramREN", 32'(ramREN), 32'd0);

        do_reset();
        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
